// File: rtl/freq_meter_pkg.sv
// Shared constants and types for the frequency meter datapath.
package freq_meter_pkg;

  localparam int CNT_W      = 32;
  localparam int BCD_DIGITS = 10;
  localparam int BCD_W      = 4 * BCD_DIGITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_t;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a nibble of 5 or more gets +3 before the shift.
module bcd_digit_adj
  import freq_meter_pkg::*;
(
  input  logic [3:0] digit_in,
  output logic [3:0] digit_out
);

  // +3 correction so the following left shift carries correctly into the next digit
  always_comb begin
    digit_out = digit_in;
    if (digit_in >= 4'd5) begin
      digit_out = digit_in + 4'd3;
    end else begin
      digit_out = digit_in;
    end
  end

endmodule

// File: rtl/freq_bcd_converter.sv
// Iterative binary-to-BCD converter for the frequency count, one bit per clock,
// started automatically whenever the incoming count changes.
module freq_bcd_converter
  import freq_meter_pkg::*;
#(
  parameter int BIN_W  = CNT_W,
  parameter int DIGITS = BCD_DIGITS
) (
  input  logic                  sys_clk,
  input  logic                  rst_n,
  input  logic [BIN_W-1:0]      bin_in,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     digit_en,
  output logic                  bcd_valid,
  output logic                  busy
);

  localparam int SW = 4 * DIGITS;
  localparam int CW = $clog2(BIN_W);
  localparam logic [CW-1:0] CNT_LAST = CW'(BIN_W - 1);

  conv_state_t       state_r;
  logic [BIN_W-1:0]  last_bin_r;
  logic [BIN_W-1:0]  bin_sr_r;
  logic [SW-1:0]     scratch_r;
  logic [CW-1:0]     cnt_r;
  logic [SW-1:0]     adj_s;

  // Significance mask: digit i is shown if it or any higher digit is nonzero.
  function automatic logic [DIGITS-1:0] digit_mask(input logic [SW-1:0] bcd);
    logic [DIGITS-1:0] mask;
    logic              seen;
    mask = '0;
    seen = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      seen    = seen | (bcd[4*i +: 4] != 4'd0);
      mask[i] = seen;
    end
    mask[0] = 1'b1;
    return mask;
  endfunction

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_in  (scratch_r[4*g +: 4]),
      .digit_out (adj_s[4*g +: 4])
    );
  end

  // Conversion sequencer with registered outputs
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      last_bin_r <= '0;
      bin_sr_r   <= '0;
      scratch_r  <= '0;
      cnt_r      <= '0;
      bcd_out    <= '0;
      digit_en   <= {{(DIGITS-1){1'b0}}, 1'b1};
      bcd_valid  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          bcd_valid <= 1'b0;
          if (bin_in != last_bin_r) begin
            state_r    <= SHIFT;
            bin_sr_r   <= bin_in;
            last_bin_r <= bin_in;
            scratch_r  <= '0;
            cnt_r      <= '0;
            busy       <= 1'b1;
          end else begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end
        end
        SHIFT: begin
          // The scratch MSB falls off the top; it stays zero while 10^DIGITS covers the range.
          {scratch_r, bin_sr_r} <= {adj_s, bin_sr_r} << 1;
          cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
          if (cnt_r == CNT_LAST) begin
            state_r <= DONE;
          end else begin
            state_r <= SHIFT;
          end
        end
        DONE: begin
          state_r   <= IDLE;
          bcd_out   <= scratch_r;
          digit_en  <= digit_mask(scratch_r);
          bcd_valid <= 1'b1;
          busy      <= 1'b0;
        end
        default: begin
          state_r   <= IDLE;
          bcd_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
